// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: captures A/B on a start handshake, walks the
// bits MSB-first one per clock, and presents a one-hot GT/EQ/LT result on a result handshake.
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [IW-1:0]    r_idx;
  logic             r_diff;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic w_a_bit;
  logic w_b_bit;
  logic w_differ;
  logic w_last;

  assign w_a_bit  = r_a_sh[WIDTH-1];
  assign w_b_bit  = r_b_sh[WIDTH-1];
  assign w_differ = w_a_bit ^ w_b_bit;
  assign w_last   = ((EARLY_EXIT != 0) && w_differ) || (r_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a_sh        <= '0;
      r_b_sh        <= '0;
      r_idx         <= '0;
      r_diff        <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_gt          <= 1'b0;
      r_eq          <= 1'b0;
      r_lt          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a_sh        <= a;
            r_b_sh        <= b;
            r_idx         <= IW'(WIDTH - 1);
            r_diff        <= 1'b0;
            r_gt          <= 1'b0;
            r_eq          <= 1'b0;
            r_lt          <= 1'b0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Only the first difference decides; later bits are ignored once r_diff is set.
          if (w_differ && !r_diff) begin
            r_gt   <= w_a_bit;
            r_lt   <= w_b_bit;
            r_diff <= 1'b1;
          end
          if (w_last) begin
            r_eq        <= !(r_diff || w_differ);
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh << 1;
            r_idx  <= r_idx - IW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign gt          = r_gt;
  assign eq          = r_eq;
  assign lt          = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: an early-exit and a full-scan instance checked every cycle
// against an arithmetic model of latency and result, plus directed literal scenarios.
module tb_serial_mag_comparator;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   sv    = 2'b00;
  logic [1:0]   rr    = 2'b11;
  logic [1:0]   sr_o, rv_o, gt_o, eq_o, lt_o, bz_o;
  logic [W-1:0] a_in [2];
  logic [W-1:0] b_in [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: index 0 is the early-exit instance, index 1 the full-scan instance.
  logic [1:0]   m_busy = 2'b00;
  int           m_due  [2];
  logic [2:0]   m_res  [2];
  logic [W-1:0] m_a    [2];
  logic [W-1:0] m_b    [2];
  int           m_done [2] = '{0, 0};

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr_o[0]),
    .a(a_in[0]), .b(b_in[0]), .res_valid(rv_o[0]), .res_ready(rr[0]),
    .gt(gt_o[0]), .eq(eq_o[0]), .lt(lt_o[0]), .busy(bz_o[0])
  );

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr_o[1]),
    .a(a_in[1]), .b(b_in[1]), .res_valid(rv_o[1]), .res_ready(rr[1]),
    .gt(gt_o[1]), .eq(eq_o[1]), .lt(lt_o[1]), .busy(bz_o[1])
  );

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    if (!ee) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 2'b00;
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          if (sv[d]) begin
            m_busy[d] <= 1'b1;
            m_due[d]  <= cyc + 1 + exp_lat(a_in[d], b_in[d], d == 0);
            m_res[d]  <= exp_res(a_in[d], b_in[d]);
            m_a[d]    <= a_in[d];
            m_b[d]    <= b_in[d];
          end
        end else if (cyc >= m_due[d] && rr[d]) begin
          m_busy[d] <= 1'b0;
          m_done[d] <= m_done[d] + 1;
          $display("txn dut%0d a=%02h b=%02h expected gt/eq/lt=%03b got=%b%b%b",
                   d, m_a[d], m_b[d], m_res[d], gt_o[d], eq_o[d], lt_o[d]);
        end
      end
    end
  end

  // Single compare process on the falling edge.
  always @(negedge clk) begin
    logic ev;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk($sformatf("rst_outs_dut%0d", d),
            int'({rv_o[d], bz_o[d], gt_o[d], eq_o[d], lt_o[d]}), 0);
      end else begin
        ev = m_busy[d] && (cyc >= m_due[d]);
        chk($sformatf("res_valid_dut%0d_cyc%0d", d, cyc), int'(rv_o[d]), int'(ev));
        chk($sformatf("start_ready_dut%0d_cyc%0d", d, cyc), int'(sr_o[d]), int'(!m_busy[d]));
        chk($sformatf("busy_dut%0d_cyc%0d", d, cyc), int'(bz_o[d]), int'(m_busy[d]));
        if (ev && rv_o[d])
          chk($sformatf("result_dut%0d_cyc%0d", d, cyc),
              int'({gt_o[d], eq_o[d], lt_o[d]}), int'(m_res[d]));
      end
    end
  end

  task automatic send(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input string nm);
    bit got;
    @(posedge clk); #1;
    sv[d] = 1'b1; a_in[d] = av; b_in[d] = bv;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = sr_o[d];
    end
    if (!got) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    // Scramble the inputs during the scan; the captured operands must be used.
    sv[d] = 1'b0; a_in[d] = ~av; b_in[d] = bv ^ 8'h5A;
  endtask

  task automatic wait_result(input int d, input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rv_o[d] && n < 100);
    if (!rv_o[d]) chk({nm, "_result_timeout"}, 0, 1);
  endtask

  task automatic run_op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] er, input int el, input string nm);
    int n;
    send(d, av, bv, nm);
    wait_result(d, nm, n);
    chk({nm, "_latency"}, n, el);
    chk({nm, "_gt_eq_lt"}, int'({gt_o[d], eq_o[d], lt_o[d]}), int'(er));
    if (rr[d]) begin
      @(posedge clk); #1;
      chk({nm, "_done_one_cycle"}, int'({rv_o[d], sr_o[d]}), 1);
    end
  endtask

  initial begin
    int n;
    a_in[0] = '0; b_in[0] = '0; a_in[1] = '0; b_in[1] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", int'({rv_o, bz_o, gt_o, eq_o, lt_o}), 0);
    rst_n = 1'b1;
    #1;
    chk("reset_start_ready", int'(sr_o), 3);

    run_op(0, 8'h80, 8'h7F, 3'b100, 1, "t1_gt_msb");
    run_op(0, 8'h3C, 8'h3D, 3'b001, 8, "t2_lt_lsb");
    run_op(0, 8'hA5, 8'hA5, 3'b010, 8, "t3_eq_a5");
    run_op(0, 8'h00, 8'h00, 3'b010, 8, "t3_eq_00");
    run_op(0, 8'hFF, 8'hFF, 3'b010, 8, "t3_eq_ff");
    run_op(1, 8'hF0, 8'h0F, 3'b100, 8, "t4_full_gt");
    run_op(1, 8'h80, 8'h7F, 3'b100, 8, "t4_full_msb");
    run_op(1, 8'h3C, 8'h3D, 3'b001, 8, "t4_full_lt");

    // Backpressure: result must hold while a new pair waits.
    rr[0] = 1'b0;
    send(0, 8'h12, 8'h34, "t5");
    wait_result(0, "t5", n);
    chk("t5_latency", n, 3);
    sv[0] = 1'b1; a_in[0] = 8'hFF; b_in[0] = 8'h00;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5_hold", int'({rv_o[0], sr_o[0], gt_o[0], eq_o[0], lt_o[0]}), 5'b10001);
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    chk("t5_idle_gap", int'({rv_o[0], sr_o[0], bz_o[0]}), 3'b010);
    @(posedge clk); #1;
    chk("t5_accept", int'({sr_o[0], bz_o[0]}), 2'b01);
    sv[0] = 1'b0;
    wait_result(0, "t5b", n);
    chk("t5b_latency", n, 1);
    chk("t5b_gt_eq_lt", int'({gt_o[0], eq_o[0], lt_o[0]}), 3'b100);
    rr[0] = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a scan.
    send(0, 8'h01, 8'h02, "t6");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("t6_reset_clear", int'({rv_o[0], bz_o[0], gt_o[0], eq_o[0], lt_o[0]}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("t6_start_ready", int'(sr_o[0]), 1);
    run_op(0, 8'h01, 8'h02, 3'b001, 7, "t6_after");

    // Randomized traffic on both instances, checked by the model.
    repeat (800) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        sv[d]   = ($urandom_range(0, 3) != 0);
        a_in[d] = W'($urandom);
        case ($urandom_range(0, 3))
          0:       b_in[d] = a_in[d];
          1:       b_in[d] = a_in[d] ^ (8'h01 << $urandom_range(0, 7));
          default: b_in[d] = W'($urandom);
        endcase
        rr[d] = ($urandom_range(0, 2) != 0);
      end
    end
    @(posedge clk); #1;
    sv = 2'b00; rr = 2'b11;
    repeat (20) @(posedge clk);
    #1;
    chk("random_ops_completed", int'(m_done[0] > 60 && m_done[1] > 40), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
